// File: rtl/neuron_scheduler.sv
// neuron_scheduler: time-multiplexes N_NEURONS virtual neurons onto one shared
// combinational neuron datapath. One timestep = IDLE -> EVAL (one neuron per
// cycle) -> DONE (one-cycle done pulse, spike vector published) -> IDLE.
// Optional feature: define NEURON_SCHED_REFRACTORY_EN to hold a neuron that
// spiked in the previous timestep at zero for one timestep (refractory period).
module neuron_scheduler #(
    parameter int N_NEURONS = 4,
    parameter int U_W       = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [2*N_NEURONS-1:0] x_in,
    input  logic                   cfg_valid,
    input  logic [1:0]             cfg_addr,
    input  logic [U_W-1:0]         cfg_data,
    output logic                   cfg_ready,
    output logic [1:0]             dp_w,
    output logic [1:0]             dp_x,
    output logic [U_W-1:0]         dp_shift,
    output logic [U_W-1:0]         dp_prev_u,
    output logic [U_W-1:0]         dp_minus_teta,
    output logic                   dp_was_spike,
    input  logic [U_W-1:0]         dp_u,
    input  logic                   dp_spike,
    output logic                   busy,
    output logic                   done,
    output logic [N_NEURONS-1:0]   spikes
);

    localparam int                IDX_W    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_NEURONS - 1);
    localparam logic [IDX_W-1:0]  IDX_ONE  = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EVAL = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                 r_state;
    logic [IDX_W-1:0]       r_idx;
    logic [1:0]             r_x [N_NEURONS];
    logic [U_W-1:0]         r_u_mem [N_NEURONS];
    logic [N_NEURONS-1:0]   r_s_mem;
    logic [1:0]             r_w;
    logic [U_W-1:0]         r_shift;
    logic [U_W-1:0]         r_minus_teta;
    logic                   r_done;
    logic [N_NEURONS-1:0]   r_spikes;

    logic [U_W-1:0]         w_u_wr;
    logic                   w_s_wr;

    assign busy      = (r_state != S_IDLE);
    assign cfg_ready = ~busy;
    assign done      = r_done;
    assign spikes    = r_spikes;

    // Present the current neuron's state and the shared config to the datapath.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        dp_w          = r_w;
        dp_shift      = r_shift;
        dp_minus_teta = r_minus_teta;
        dp_prev_u     = r_u_mem[r_idx];
        dp_x          = 2'b00;
        dp_was_spike  = 1'b0;
        if (r_state == S_EVAL) begin
            dp_x         = r_x[r_idx];
            dp_was_spike = r_s_mem[r_idx];
        end
    end

    // Select the value written back for the neuron under evaluation.
    always_comb begin
        w_u_wr = dp_u;
        w_s_wr = dp_spike;
`ifdef NEURON_SCHED_REFRACTORY_EN
        // s_mem[idx] is still the previous timestep's spike: this entry is only rewritten at its own slot.
        if (r_s_mem[r_idx]) begin
            w_u_wr = '0;
            w_s_wr = 1'b0;
        end
`else
`endif
    end

    // Timestep FSM, config registers and per-neuron state memories.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_idx        <= '0;
            r_done       <= 1'b0;
            r_spikes     <= '0;
            r_s_mem      <= '0;
            r_w          <= 2'd1;
            r_shift      <= U_W'(1);
            r_minus_teta <= U_W'(5);
            // NOTE: the membrane memory is reset explicitly because neurons must restart from rest after reset;
            // it is small enough to live in flops rather than a RAM macro.
            for (int i = 0; i < N_NEURONS; i++) begin
                r_u_mem[i] <= '0;
                r_x[i]     <= 2'b00;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_valid) begin
                        case (cfg_addr)
                            2'd0: r_w          <= cfg_data[1:0];
                            2'd1: r_shift      <= cfg_data;
                            2'd2: r_minus_teta <= cfg_data;
                            default: begin
                                r_s_mem <= '0;
                                for (int i = 0; i < N_NEURONS; i++) begin
                                    r_u_mem[i] <= '0;
                                end
                            end
                        endcase
                    end
                    if (start) begin
                        for (int i = 0; i < N_NEURONS; i++) begin
                            r_x[i] <= x_in[2*i +: 2];
                        end
                        r_idx   <= '0;
                        r_state <= S_EVAL;
                    end
                end
                S_EVAL: begin
                    r_u_mem[r_idx] <= w_u_wr;
                    r_s_mem[r_idx] <= w_s_wr;
                    if (r_idx == LAST_IDX) begin
                        // The last neuron's spike is taken straight from the write-back value.
                        r_spikes <= {w_s_wr, r_s_mem[N_NEURONS-2:0]};
                        r_done   <= 1'b1;
                        r_idx    <= '0;
                        r_state  <= S_DONE;
                    end else begin
                        r_idx <= r_idx + IDX_ONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_scheduler.sv
// Self-checking bench for neuron_scheduler: randomized timesteps and config
// traffic checked against an array-based reference model of the neuron rules.
module tb_neuron_scheduler;

    localparam int N  = 4;
    localparam int UW = 3;

    logic            clk = 1'b0;
    logic            reset, start, cfg_valid;
    logic [2*N-1:0]  x_in;
    logic [1:0]      cfg_addr;
    logic [UW-1:0]   cfg_data;
    logic            cfg_ready, dp_was_spike, dp_spike, busy, done;
    logic [1:0]      dp_w, dp_x;
    logic [UW-1:0]   dp_shift, dp_prev_u, dp_minus_teta, dp_u;
    logic [N-1:0]    spikes;
    logic [3:0]      w_sum;

    always #5 clk = ~clk;

    // Datapath stub: saturating accumulate, spike on threshold.
    assign w_sum    = {1'b0, dp_prev_u} + {2'b00, dp_x};
    assign dp_u     = (w_sum > 4'd7) ? 3'd7 : w_sum[2:0];
    assign dp_spike = (dp_u >= dp_minus_teta);

    neuron_scheduler #(.N_NEURONS(N), .U_W(UW)) dut (
        .clk(clk), .reset(reset), .start(start), .x_in(x_in),
        .cfg_valid(cfg_valid), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .cfg_ready(cfg_ready), .dp_w(dp_w), .dp_x(dp_x), .dp_shift(dp_shift),
        .dp_prev_u(dp_prev_u), .dp_minus_teta(dp_minus_teta),
        .dp_was_spike(dp_was_spike), .dp_u(dp_u), .dp_spike(dp_spike),
        .busy(busy), .done(done), .spikes(spikes)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    int m_u [N];
    int m_s [N];
    int m_spikes, m_w, m_shift, m_teta;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_u[i] = 0;
            m_s[i] = 0;
        end
        m_spikes = 0; m_w = 1; m_shift = 1; m_teta = 5;
    endtask

    task automatic model_cfg(input int addr, input int data);
        case (addr)
            0: m_w = data & 3;
            1: m_shift = data;
            2: m_teta = data;
            default: for (int i = 0; i < N; i++) begin m_u[i] = 0; m_s[i] = 0; end
        endcase
    endtask

    task automatic model_step(input logic [2*N-1:0] x);
        int xi;
        m_spikes = 0;
        for (int i = 0; i < N; i++) begin
            xi = (int'(x) >> (2*i)) & 3;
`ifdef NEURON_SCHED_REFRACTORY_EN
            if (m_s[i] == 1) begin
                m_u[i] = 0;
                m_s[i] = 0;
            end else begin
                m_u[i] = (m_u[i] + xi > 7) ? 7 : m_u[i] + xi;
                m_s[i] = (m_u[i] >= m_teta) ? 1 : 0;
            end
`else
            m_u[i] = (m_u[i] + xi > 7) ? 7 : m_u[i] + xi;
            m_s[i] = (m_u[i] >= m_teta) ? 1 : 0;
`endif
            m_spikes = m_spikes | (m_s[i] << i);
        end
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [UW-1:0] data);
        cfg_valid = 1'b1; cfg_addr = addr; cfg_data = data;
        @(posedge clk); #1;
        cfg_valid = 1'b0;
        model_cfg(int'(addr), int'(data));
        check("cfg_busy",       32'(busy),          32'd0);
        check("cfg_teta",       32'(dp_minus_teta), 32'(m_teta));
        check("cfg_w",          32'(dp_w),          32'(m_w));
        check("cfg_shift",      32'(dp_shift),      32'(m_shift));
        check("cfg_prev_u0",    32'(dp_prev_u),     32'(m_u[0]));
    endtask

    // One timestep; optional config with start, junk traffic while busy, or reset at slot abort_at.
    task automatic do_timestep(input logic [2*N-1:0] x, input bit cv, input logic [1:0] ca,
                               input logic [UW-1:0] cd, input bit junk, input int abort_at);
        logic [1:0] xk;
        x_in = x; start = 1'b1; cfg_valid = cv; cfg_addr = ca; cfg_data = cd;
        @(posedge clk); #1;
        start = 1'b0; cfg_valid = 1'b0;
        if (cv) model_cfg(int'(ca), int'(cd));
        for (int k = 0; k < N; k++) begin
            if (k == abort_at) begin
                reset = 1'b1;
                @(posedge clk); #1;
                reset = 1'b0;
                model_reset();
                check("abort_busy",   32'(busy),      32'd0);
                check("abort_done",   32'(done),      32'd0);
                check("abort_spikes", 32'(spikes),    32'd0);
                check("abort_u0",     32'(dp_prev_u), 32'd0);
                check("abort_teta",   32'(dp_minus_teta), 32'd5);
                repeat (N + 2) begin
                    @(posedge clk); #1;
                    check("abort_no_done", 32'(done), 32'd0);
                end
                return;
            end
            xk = x[2*k +: 2];
            check("eval_busy",      32'(busy),          32'd1);
            check("eval_done",      32'(done),          32'd0);
            check("eval_cfg_ready", 32'(cfg_ready),     32'd0);
            check("eval_dp_x",      32'(dp_x),          32'(xk));
            check("eval_prev_u",    32'(dp_prev_u),     32'(m_u[k]));
            check("eval_was_spike", 32'(dp_was_spike),  32'(m_s[k]));
            check("eval_teta",      32'(dp_minus_teta), 32'(m_teta));
            check("eval_w",         32'(dp_w),          32'(m_w));
            check("eval_shift",     32'(dp_shift),      32'(m_shift));
            if (junk) begin
                start = 1'b1; cfg_valid = 1'b1;
                cfg_addr = 2'($urandom_range(3, 0));
                cfg_data = 3'($urandom_range(7, 0));
                x_in = 8'($urandom);
            end
            @(posedge clk); #1;
            start = 1'b0; cfg_valid = 1'b0;
        end
        model_step(x);
        check("done_pulse",     32'(done),         32'd1);
        check("done_busy",      32'(busy),         32'd1);
        check("done_spikes",    32'(spikes),       32'(m_spikes));
        check("done_dp_x",      32'(dp_x),         32'd0);
        check("done_was_spike", 32'(dp_was_spike), 32'd0);
        if (junk) begin
            start = 1'b1; cfg_valid = 1'b1;
            cfg_addr = 2'($urandom_range(3, 0));
            cfg_data = 3'($urandom_range(7, 0));
        end
        @(posedge clk); #1;
        start = 1'b0; cfg_valid = 1'b0;
        check("idle_done",      32'(done),          32'd0);
        check("idle_busy",      32'(busy),          32'd0);
        check("idle_cfg_ready", 32'(cfg_ready),     32'd1);
        check("idle_spikes",    32'(spikes),        32'(m_spikes));
        check("idle_dp_x",      32'(dp_x),          32'd0);
        check("idle_prev_u0",   32'(dp_prev_u),     32'(m_u[0]));
        check("idle_teta",      32'(dp_minus_teta), 32'(m_teta));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; cfg_valid = 1'b0;
        cfg_addr = 2'd0; cfg_data = '0; x_in = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();

        // Reset state
        check("rst_busy",      32'(busy),          32'd0);
        check("rst_done",      32'(done),          32'd0);
        check("rst_spikes",    32'(spikes),        32'd0);
        check("rst_cfg_ready", 32'(cfg_ready),     32'd1);
        check("rst_w",         32'(dp_w),          32'd1);
        check("rst_shift",     32'(dp_shift),      32'd1);
        check("rst_teta",      32'(dp_minus_teta), 32'd5);
        check("rst_dp_x",      32'(dp_x),          32'd0);
        check("rst_was_spike", 32'(dp_was_spike),  32'd0);

        // Single timestep, every neuron gets +1, no spikes
        do_timestep(8'b01_01_01_01, 1'b0, 2'd0, 3'd0, 1'b0, -1);
        check("basic_spikes", 32'(spikes), 32'd0);

        // Neuron 0 accumulates 3 per timestep over five timesteps
        cfg_write(2'd3, 3'd0);
        for (int t = 0; t < 5; t++) begin
            do_timestep(8'b00_00_00_11, 1'b0, 2'd0, 3'd0, 1'b0, -1);
            check("acc_spikes_hi", 32'(spikes[N-1:1]), 32'd0);
        end

        // Threshold lowered together with start
        cfg_write(2'd3, 3'd0);
        do_timestep(8'b10_00_00_00, 1'b1, 2'd2, 3'd2, 1'b0, -1);
        check("cfg_with_start_spikes", 32'(spikes), 32'b1000);

        // Start and config traffic while busy must be ignored
        do_timestep(8'($urandom), 1'b0, 2'd0, 3'd0, 1'b1, -1);
        do_timestep(8'($urandom), 1'b0, 2'd0, 3'd0, 1'b1, -1);

        // Reset in the middle of a timestep, then confirm memories are clear
        do_timestep(8'hFF, 1'b0, 2'd0, 3'd0, 1'b0, 2);
        do_timestep(8'h00, 1'b0, 2'd0, 3'd0, 1'b0, -1);

        // Randomized traffic
        for (int r = 0; r < 40; r++) begin
            if ($urandom_range(3, 0) == 0)
                cfg_write(2'($urandom_range(3, 0)), 3'($urandom_range(7, 0)));
            repeat ($urandom_range(2, 0)) begin
                @(posedge clk); #1;
                check("gap_busy", 32'(busy), 32'd0);
            end
            do_timestep(8'($urandom), 1'($urandom_range(1, 0)), 2'($urandom_range(3, 0)),
                        3'($urandom_range(7, 0)), 1'($urandom_range(1, 0)), -1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Global watchdog so the run always ends on its own
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
